// File: rtl/bram_acq_ctrl.sv
// Acquisition BRAM ownership sequencer: guards the BUFGMUX switch, streams AXIS beats into port A.
// Optional BRAM_ACQ_CTRL_DROP_CNT_EN: always-ready sink that counts beats discarded outside FILL.
module bram_acq_ctrl #(
  parameter int unsigned BRAM_DATA_WIDTH = 32,
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned GUARD_CYCLES    = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       cfg_start,
  input  logic                       cfg_abort,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_length,
  input  logic                       read_done,
  input  logic [BRAM_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic                       switch,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram_porta_wrdata,
  output logic                       bram_porta_we,
  output logic                       data_ready,
  output logic [2:0]                 sts_state,
  output logic [BRAM_ADDR_WIDTH:0]   sts_words,
  output logic [31:0]                sts_dropped
);

  localparam int unsigned CntW  = $clog2(GUARD_CYCLES + 2);
  localparam int unsigned WordW = BRAM_ADDR_WIDTH + 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StGuardA = 3'd1;
  localparam logic [2:0] StFill   = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StGuardB = 3'd4;
  localparam logic [2:0] StReady  = 3'd5;

  localparam logic [CntW-1:0]  GuardLast = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0]  DrainLast = CntW'(1);
  localparam logic [WordW-1:0] FullDepth = {1'b1, {BRAM_ADDR_WIDTH{1'b0}}};

  logic [2:0]                 state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [WordW-1:0]           len_q, len_d;
  logic [WordW-1:0]           words_q, words_d;
  logic                       switch_q, data_ready_q, we_q;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q;
  logic [BRAM_DATA_WIDTH-1:0] wrdata_q;
  logic                       accept;

  assign accept = s_axis_tvalid & s_axis_tready & (state_q == StFill);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    words_d = words_q;
    case (state_q)
      StIdle: begin
        if (cfg_start) begin
          len_d   = (cfg_length == '0) ? FullDepth : {1'b0, cfg_length};
          words_d = '0;
          cnt_d   = '0;
          state_d = StGuardA;
        end
      end
      StGuardA: begin
        if (cfg_abort) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else if (cnt_q == GuardLast) begin
          state_d = StFill;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFill: begin
        if (accept) words_d = words_q + 1'b1;
        if (cfg_abort || (accept && (words_d == len_q))) begin
          cnt_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Two cycles so the last registered write reaches the BRAM before the clock mux flips.
        if (cnt_q == DrainLast) begin
          cnt_d   = '0;
          state_d = StGuardB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGuardB: begin
        if (cnt_q == GuardLast) state_d = StReady;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      StReady: begin
        if (read_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      len_q        <= '0;
      words_q      <= '0;
      switch_q     <= 1'b0;
      data_ready_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wrdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      words_q      <= words_d;
      switch_q     <= (state_d == StGuardA) || (state_d == StFill) || (state_d == StDrain);
      data_ready_q <= (state_d == StReady);
      we_q         <= accept;
      if (accept) begin
        addr_q   <= words_q[BRAM_ADDR_WIDTH-1:0];
        wrdata_q <= s_axis_tdata;
      end
    end
  end

`ifdef BRAM_ACQ_CTRL_DROP_CNT_EN
  logic        rst_done_q;
  logic [31:0] dropped_q;

  assign s_axis_tready = rst_done_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (s_axis_tvalid && s_axis_tready && (state_q != StFill) && (dropped_q != '1)) begin
        dropped_q <= dropped_q + 1'b1;
      end
    end
  end

  assign sts_dropped = dropped_q;
`else
  assign s_axis_tready = (state_q == StFill);
  assign sts_dropped   = '0;
`endif

  assign switch            = switch_q;
  assign data_ready        = data_ready_q;
  assign bram_porta_we     = we_q;
  assign bram_porta_addr   = addr_q;
  assign bram_porta_wrdata = wrdata_q;
  assign sts_state         = state_q;
  assign sts_words         = words_q;

endmodule

// File: tb/tb_bram_acq_ctrl.sv
// Directed self-checking bench for bram_acq_ctrl (GUARD_CYCLES=4, BRAM_ADDR_WIDTH=4).
module tb_bram_acq_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned G  = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          read_done = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [AW-1:0] cfg_length = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tready, switch, bram_porta_we, data_ready;
  logic [AW-1:0] bram_porta_addr;
  logic [DW-1:0] bram_porta_wrdata;
  logic [2:0]    sts_state;
  logic [AW:0]   sts_words;
  logic [31:0]   sts_dropped;

  bram_acq_ctrl #(
    .BRAM_DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW),
    .GUARD_CYCLES   (G)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cfg_start        (cfg_start),
    .cfg_abort        (cfg_abort),
    .cfg_length       (cfg_length),
    .read_done        (read_done),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .switch           (switch),
    .bram_porta_addr  (bram_porta_addr),
    .bram_porta_wrdata(bram_porta_wrdata),
    .bram_porta_we    (bram_porta_we),
    .data_ready       (data_ready),
    .sts_state        (sts_state),
    .sts_words        (sts_words),
    .sts_dropped      (sts_dropped)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];

  always @(negedge aclk) begin
    if (bram_porta_we) begin
      wa.push_back(bram_porta_addr);
      wd.push_back(bram_porta_wrdata);
    end
  end

  int   first_rdy, sw_cyc, rdy_lat, beats;
  logic done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one capture from the start pulse until data_ready; tvalid high every duty-th cycle.
  task capture(input int len, input int duty, input int abort_after);
    int   fall_k;
    logic acc;
    logic aborted;
    wa.delete();
    wd.delete();
    beats = 0; first_rdy = -1; fall_k = -1; rdy_lat = -1; done = 1'b0;
    sw_cyc = 1;  // the start-pulse cycle itself
    acc = 1'b0; aborted = 1'b0;
    @(negedge aclk);
    cfg_length    = AW'(len);
    cfg_start     = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge aclk);
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      if (acc) begin
        beats++;
        s_axis_tdata = DW'(beats);
      end
      if (sts_state == 3'd2 && first_rdy < 0) first_rdy = k;
      if (switch) sw_cyc++;
      if (!switch && sw_cyc > 1 && fall_k < 0) fall_k = k;
      if (data_ready) begin
        rdy_lat = k - fall_k;
        done    = 1'b1;
        break;
      end
      s_axis_tvalid = ((k % duty) == 0);
      if (abort_after > 0 && beats == abort_after && !aborted) begin
        cfg_abort     = 1'b1;
        s_axis_tvalid = 1'b0;
        aborted       = 1'b1;
      end
      acc = s_axis_tvalid && s_axis_tready && (sts_state == 3'd2);
    end
    s_axis_tvalid = 1'b0;
    chk("ready_reached", done, 1'b1);
  endtask

  task check_writes(input int n);
    chk("write_count", wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk("write_addr", wa[i], i);
      chk("write_data", wd[i], i);
    end
  endtask

  task ack();
    @(negedge aclk);
    read_done = 1'b1;
    @(negedge aclk);
    read_done = 1'b0;
    chk("ack_state_idle", sts_state, 3'd0);
    chk("ack_data_ready", data_ready, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_state", sts_state, 3'd0);
    chk("rst_switch", switch, 1'b0);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_we", bram_porta_we, 1'b0);
    chk("rst_addr", bram_porta_addr, 0);
    chk("rst_wrdata", bram_porta_wrdata, 0);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_words", sts_words, 0);
    chk("rst_dropped", sts_dropped, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Length 8, continuous tvalid: switch covers start + 4 guard + 8 fill + 2 drain.
    capture(8, 1, 0);
    chk("l8_first_fill", first_rdy, G + 1);
    chk("l8_switch_cycles", sw_cyc, 15);
    chk("l8_ready_latency", rdy_lat, G);
    chk("l8_words", sts_words, 8);
    chk("l8_state", sts_state, 3'd5);
    chk("l8_switch_ready", switch, 1'b0);
    check_writes(8);
    ack();

    // Length 0 means full depth (16), no wrap.
    capture(0, 1, 0);
    chk("l0_words", sts_words, 16);
    check_writes(16);
    ack();

    // Bursty tvalid, one of three cycles.
    capture(5, 3, 0);
    chk("burst_words", sts_words, 5);
    chk("burst_we_per_beat", wa.size(), beats);
    check_writes(5);
    ack();

    // Abort after three beats of ten.
    capture(10, 1, 3);
    chk("abort_words", sts_words, 3);
    repeat (3) @(negedge aclk);
    chk("abort_state_ready", sts_state, 3'd5);
    check_writes(3);
    ack();

    // Spurious start in GUARD_A, read_done in FILL, then async reset mid-FILL.
    @(negedge aclk);
    cfg_length = 4'd12; cfg_start = 1'b1; s_axis_tvalid = 1'b1;
    @(negedge aclk); cfg_start = 1'b0;
    @(negedge aclk); cfg_start = 1'b1;
    @(negedge aclk); cfg_start = 1'b0;
    @(negedge aclk);
    chk("guard_a_state", sts_state, 3'd1);
    @(negedge aclk);
    chk("restart_ignored", sts_state, 3'd2);
    read_done = 1'b1;
    @(negedge aclk); read_done = 1'b0;
    chk("read_done_ignored", sts_state, 3'd2);
    @(negedge aclk);
    chk("we_before_reset", bram_porta_we, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_switch", switch, 1'b0);
    chk("arst_we", bram_porta_we, 1'b0);
    chk("arst_tready", s_axis_tready, 1'b0);
    chk("arst_ready", data_ready, 1'b0);
    chk("arst_state", sts_state, 3'd0);
    s_axis_tvalid = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_state", sts_state, 3'd0);
    read_done = 1'b1;
    @(negedge aclk); read_done = 1'b0;
    @(negedge aclk);
    chk("idle_read_done_state", sts_state, 3'd0);
    chk("idle_read_done_ready", data_ready, 1'b0);

    // Six valid beats while idle.
    wa.delete();
    wd.delete();
    s_axis_tvalid = 1'b1;
    repeat (6) @(negedge aclk);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
`ifdef BRAM_ACQ_CTRL_DROP_CNT_EN
    chk("idle_dropped", sts_dropped, 6);
    chk("idle_tready", s_axis_tready, 1'b1);
`else
    chk("idle_dropped", sts_dropped, 0);
    chk("idle_tready", s_axis_tready, 1'b0);
`endif
    chk("idle_no_we", wa.size(), 0);
    chk("idle_state", sts_state, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
